rw_job_scheduler: RTL

Schedules jobs from NUM_REQ requesters onto the single shared read/process/write engine, granting one requester at a time in round-robin order. It drives the engine's start pulse, watches for completion, error and timeout, and aborts and retries failed jobs up to MAX_RETRY times. It reports a per-requester done or fail pulse. It sits between the client request ports and the engine, and is the only block allowed to start or abort the engine.

---
 rtl/rw_sched_pkg.sv | 25 ++
 rtl/rr_pick.sv | 35 +++
 rtl/rw_job_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rw_sched_pkg.sv
// Shared types and sizing helpers for the round-robin job scheduler.
//   state_e  : scheduler FSM encoding
//   timer_w  : width of the WAIT/RECOVER cycle timer
//   retry_w  : width of the retry counter (never below 1 bit)
package rw_sched_pkg;

  // ABORT is the single cycle that drives eng_abort; it counts as the
  // first cycle of the recovery window.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    RECOVER = 3'd3,
    ABORT   = 3'd4
  } state_e;

  function automatic int timer_w(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  function automatic int retry_w(input int unsigned max_retry);
    return ($clog2(max_retry + 1) < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward
// from ptr+1 with wrap.
//   req     : request vector
//   ptr     : index of the last served requester
//   pick_c  : one-hot winner (0 when none)
//   idx_c   : winner index
//   valid_c : any request present
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] pick_c,
  output logic [IW-1:0]      idx_c,
  output logic               valid_c
);

  always_comb begin
    int unsigned j;
    pick_c  = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    j       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      j = (32'(ptr) + i) % NUM_REQ;
      if (!valid_c && req[IW'(j)]) begin
        valid_c          = 1'b1;
        idx_c            = IW'(j);
        pick_c[IW'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rw_job_scheduler.sv
// Round-robin scheduler for the shared read/process/write engine. Grants one
// requester at a time, launches the engine, aborts on error/timeout and
// relaunches up to MAX_RETRY times.
//   clk, reset          : clock, async active-high reset
//   req                 : level request per requester
//   grant               : one-hot owner of the current job
//   job_done / job_fail : one-cycle completion / give-up pulse on owner's bit
//   eng_start/eng_abort : engine control pulses
//   eng_busy/eng_done/eng_error : engine status
//   busy                : scheduler not idle
//   fault               : sticky, engine stuck busy after abort
module rw_job_scheduler
  import rw_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] job_done,
  output logic [NUM_REQ-1:0] job_fail,
  output logic               eng_start,
  output logic               eng_abort,
  input  logic               eng_busy,
  input  logic               eng_done,
  input  logic               eng_error,
  output logic               busy,
  output logic               fault
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = timer_w(TIMEOUT);
  localparam int unsigned RW = retry_w(MAX_RETRY);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   job_done_q, job_done_d;
  logic [NUM_REQ-1:0]   job_fail_q, job_fail_d;
  logic                 fault_q, fault_d;

  logic [NUM_REQ-1:0]   pick_c;
  logic [IW-1:0]        pick_idx_c;
  logic                 pick_valid_c;
  logic                 tmo_c;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .pick_c  (pick_c),
    .idx_c   (pick_idx_c),
    .valid_c (pick_valid_c)
  );

  assign tmo_c = (timer_q == TW'(TIMEOUT - 1));

  // Next-state and registered-output logic. The timer is zeroed on entry to
  // LAUNCH and ABORT so the abort lands exactly TIMEOUT cycles after start.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    grant_d    = grant_q;
    job_done_d = '0;
    job_fail_d = '0;
    fault_d    = fault_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_c && !fault_q) begin
          owner_d = pick_idx_c;
          grant_d = pick_c;
          retry_d = '0;
          timer_d = '0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = timer_q + TW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (eng_done) begin
          job_done_d = grant_q;
          grant_d    = '0;
          ptr_d      = owner_q;
          timer_d    = '0;
          state_d    = IDLE;
        end else if (eng_error || tmo_c) begin
          timer_d = '0;
          state_d = ABORT;
        end
      end
      ABORT: begin
        timer_d = timer_q + TW'(1);
        state_d = RECOVER;
      end
      RECOVER: begin
        timer_d = timer_q + TW'(1);
        if (!eng_busy) begin
          timer_d = '0;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = LAUNCH;
          end else begin
            job_fail_d = grant_q;
            grant_d    = '0;
            ptr_d      = owner_q;
            state_d    = IDLE;
          end
        end else if (tmo_c) begin
          fault_d    = 1'b1;
          job_fail_d = grant_q;
          grant_d    = '0;
          timer_d    = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(NUM_REQ - 1);
      owner_q    <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      grant_q    <= '0;
      job_done_q <= '0;
      job_fail_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      grant_q    <= grant_d;
      job_done_q <= job_done_d;
      job_fail_q <= job_fail_d;
      fault_q    <= fault_d;
    end
  end

  assign grant     = grant_q;
  assign job_done  = job_done_q;
  assign job_fail  = job_fail_q;
  assign fault     = fault_q;
  assign eng_start = (state_q == LAUNCH);
  assign eng_abort = (state_q == ABORT);
  assign busy      = (state_q != IDLE);

endmodule
